// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store execute stage: FSM states, decoded ops,
// decode flag positions, exception causes and byte_size codes.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } lsu_state_t;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_LB,
    OP_LBU,
    OP_LH,
    OP_LHU,
    OP_LW,
    OP_SB,
    OP_SH,
    OP_SW
  } lsu_op_t;

  localparam int FLAG_LB  = 29;
  localparam int FLAG_LBU = 30;
  localparam int FLAG_LH  = 31;
  localparam int FLAG_LHU = 32;
  localparam int FLAG_LW  = 33;
  localparam int FLAG_SB  = 34;
  localparam int FLAG_SH  = 35;
  localparam int FLAG_SW  = 36;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  localparam logic [1:0] BSIZE_WORD = 2'd0;
  localparam logic [1:0] BSIZE_BYTE = 2'd1;
  localparam logic [1:0] BSIZE_HALF = 2'd2;

  // Decode flags are nominally one-hot; if several memory bits are set the lowest index wins.
  function automatic lsu_op_t decode_op(input logic [47:0] flags);
    lsu_op_t op;
    if (flags[FLAG_LB])       op = OP_LB;
    else if (flags[FLAG_LBU]) op = OP_LBU;
    else if (flags[FLAG_LH])  op = OP_LH;
    else if (flags[FLAG_LHU]) op = OP_LHU;
    else if (flags[FLAG_LW])  op = OP_LW;
    else if (flags[FLAG_SB])  op = OP_SB;
    else if (flags[FLAG_SH])  op = OP_SH;
    else if (flags[FLAG_SW])  op = OP_SW;
    else                      op = OP_NONE;
    return op;
  endfunction

  function automatic logic is_load(input lsu_op_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic logic [1:0] size_of(input lsu_op_t op);
    logic [1:0] sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = BSIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = BSIZE_HALF;
      default:              sz = BSIZE_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: shifts store data into its lanes with matching strobes,
// and pulls a load lane out of the bus word with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = 2
) (
  input  lsu_op_t               st_op,
  input  logic [OFF_W-1:0]      st_off,
  input  logic [XLEN-1:0]       rs2_data,
  output logic [XLEN-1:0]       st_data,
  output logic [XLEN/8-1:0]     st_strb,
  input  lsu_op_t               ld_op,
  input  logic [OFF_W-1:0]      ld_off,
  input  logic [XLEN-1:0]       mem_data_in,
  output logic [XLEN-1:0]       ld_data
);
  localparam int STRB_W = XLEN / 8;

  logic [XLEN-1:0] lane;
  logic            unused_lane;

  assign st_data     = rs2_data << {st_off, 3'b000};
  assign lane        = mem_data_in >> {ld_off, 3'b000};
  assign unused_lane = &{1'b0, lane};

  always_comb begin
    st_strb = '0;
    case (st_op)
      OP_SB:   st_strb = STRB_W'(1) << st_off;
      OP_SH:   st_strb = STRB_W'(3) << st_off;
      OP_SW:   st_strb = STRB_W'(15) << st_off;
      default: st_strb = '0;
    endcase
  end

  // lw is sign-extended too, which only matters on a 64-bit datapath.
  always_comb begin
    ld_data = '0;
    case (ld_op)
      OP_LB:   ld_data = XLEN'($signed(lane[7:0]));
      OP_LBU:  ld_data = XLEN'(lane[7:0]);
      OP_LH:   ld_data = XLEN'($signed(lane[15:0]));
      OP_LHU:  ld_data = XLEN'(lane[15:0]);
      OP_LW:   ld_data = XLEN'($signed(lane[31:0]));
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ex_lsu.sv
// Load/store execute stage: issues bus reads/writes, aligns lanes, extends load
// data, and turns misalignment or bus timeouts into one-cycle exceptions.
module ex_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ADDR_W        = 32,
  parameter int TIMEOUT_CYC   = 256,
  parameter int MISALIGN_TRAP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          rd,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic [11:0]         imm_2031,
  input  logic [47:0]         inst_flags,
  input  logic [XLEN-1:0]     mem_data_in,
  input  logic                mem_read_ready,
  input  logic                mem_write_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_data,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic [1:0]          byte_size,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic                busy_flag,
  output logic                wb_rd_wait,
  output logic [4:0]          rd_out,
  output logic                rd_en,
  output logic [XLEN-1:0]     rd_data,
  output logic                exc_valid,
  output logic [3:0]          exc_cause,
  output logic [ADDR_W-1:0]   exc_addr
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  lsu_state_t        state;
  lsu_op_t           op_in;
  lsu_op_t           op_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] ea_q;
  logic [CNT_W-1:0]  cnt;

  logic [XLEN-1:0]   ea_full;
  logic [ADDR_W-1:0] ea_raw;
  logic [ADDR_W-1:0] ea_eff;
  logic              is_half;
  logic              is_word;
  logic              misaligned;
  logic              trap;
  logic              timed_out;
  logic [XLEN-1:0]   st_data;
  logic [STRB_W-1:0] st_strb;
  logic [XLEN-1:0]   ld_data;
  logic              unused_bits;

  assign op_in       = decode_op(inst_flags);
  assign ea_full     = rs1_data + XLEN'($signed(imm_2031));
  assign ea_raw      = ea_full[ADDR_W-1:0];
  assign is_half     = op_in inside {OP_LH, OP_LHU, OP_SH};
  assign is_word     = op_in inside {OP_LW, OP_SW};
  assign misaligned  = (is_half && ea_raw[0]) || (is_word && (ea_raw[1:0] != 2'b00));
  assign trap        = misaligned && (MISALIGN_TRAP != 0);
  assign timed_out   = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);
  assign unused_bits = &{1'b0, inst_flags[47:37], inst_flags[28:0], ea_full};

  // Without trapping, a misaligned access is silently pulled down to its natural boundary.
  always_comb begin
    ea_eff = ea_raw;
    if (MISALIGN_TRAP == 0) begin
      if (is_half) ea_eff[0] = 1'b0;
      if (is_word) ea_eff[1:0] = 2'b00;
    end
  end

  lsu_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_align (
    .st_op       (op_in),
    .st_off      (ea_eff[OFF_W-1:0]),
    .rs2_data    (rs2_data),
    .st_data     (st_data),
    .st_strb     (st_strb),
    .ld_op       (op_q),
    .ld_off      (off_q),
    .mem_data_in (mem_data_in),
    .ld_data     (ld_data)
  );

  assign busy_flag  = ((state == ST_IDLE) && (op_in != OP_NONE)) ||
                      (state == ST_READ) || (state == ST_WRITE) || (state == ST_ERR);
  assign wb_rd_wait = (state == ST_READ) || ((state == ST_IDLE) && is_load(op_in));

  // Every bus-facing and writeback output is registered; rd_en and exc_valid are one-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      op_q         <= OP_NONE;
      off_q        <= '0;
      ea_q         <= '0;
      cnt          <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_wstrb    <= '0;
      byte_size    <= BSIZE_WORD;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      rd_out       <= '0;
      rd_en        <= 1'b0;
      rd_data      <= '0;
      exc_valid    <= 1'b0;
      exc_cause    <= '0;
      exc_addr     <= '0;
    end else begin
      rd_en     <= 1'b0;
      exc_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_in != OP_NONE) begin
            op_q      <= op_in;
            off_q     <= ea_eff[OFF_W-1:0];
            ea_q      <= ea_eff;
            cnt       <= '0;
            byte_size <= size_of(op_in);
            rd_out    <= is_load(op_in) ? rd : 5'd0;
            if (trap) begin
              exc_valid <= 1'b1;
              exc_cause <= is_load(op_in) ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
              exc_addr  <= ea_eff;
              state     <= ST_ERR;
            end else if (is_load(op_in)) begin
              mem_addr    <= ea_eff;
              mem_read_en <= 1'b1;
              state       <= ST_READ;
            end else begin
              mem_addr     <= ea_eff;
              mem_data     <= st_data;
              mem_wstrb    <= st_strb;
              mem_write_en <= 1'b1;
              state        <= ST_WRITE;
            end
          end else begin
            rd_out <= 5'd0;
          end
        end
        ST_READ: begin
          if (mem_read_ready) begin
            rd_data     <= ld_data;
            rd_en       <= 1'b1;
            mem_read_en <= 1'b0;
            cnt         <= '0;
            state       <= ST_DONE;
          end else if (timed_out) begin
            mem_read_en <= 1'b0;
            exc_valid   <= 1'b1;
            exc_cause   <= CAUSE_LD_FAULT;
            exc_addr    <= ea_q;
            cnt         <= '0;
            state       <= ST_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (mem_write_ready) begin
            mem_write_en <= 1'b0;
            mem_wstrb    <= '0;
            cnt          <= '0;
            state        <= ST_DONE;
          end else if (timed_out) begin
            mem_write_en <= 1'b0;
            mem_wstrb    <= '0;
            exc_valid    <= 1'b1;
            exc_cause    <= CAUSE_ST_FAULT;
            exc_addr     <= ea_q;
            cnt          <= '0;
            state        <= ST_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_lsu.sv
// Self-checking bench for ex_lsu: directed corner cases followed by random
// loads/stores compared against an arithmetic model of RISC-V access rules.
module tb_ex_lsu;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam int TO     = 8;
  localparam logic [47:0] MEM_MASK = 48'h00_1F_E000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        rd;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [11:0]       imm_2031;
  logic [47:0]       inst_flags;
  logic [XLEN-1:0]   mem_data_in;
  logic              mem_read_ready;
  logic              mem_write_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_data;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [1:0]        byte_size;
  logic              mem_read_en;
  logic              mem_write_en;
  logic              busy_flag;
  logic              wb_rd_wait;
  logic [4:0]        rd_out;
  logic              rd_en;
  logic [XLEN-1:0]   rd_data;
  logic              exc_valid;
  logic [3:0]        exc_cause;
  logic [ADDR_W-1:0] exc_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_lsu #(
    .XLEN          (XLEN),
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYC   (TO),
    .MISALIGN_TRAP (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rd              (rd),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .imm_2031        (imm_2031),
    .inst_flags      (inst_flags),
    .mem_data_in     (mem_data_in),
    .mem_read_ready  (mem_read_ready),
    .mem_write_ready (mem_write_ready),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .mem_wstrb       (mem_wstrb),
    .byte_size       (byte_size),
    .mem_read_en     (mem_read_en),
    .mem_write_en    (mem_write_en),
    .busy_flag       (busy_flag),
    .wb_rd_wait      (wb_rd_wait),
    .rd_out          (rd_out),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .exc_valid       (exc_valid),
    .exc_cause       (exc_cause),
    .exc_addr        (exc_addr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Op index: 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 sb, 6 sh, 7 sw.
  function automatic int op_size(input int op);
    if (op == 0 || op == 1 || op == 5) return 1;
    if (op == 2 || op == 3 || op == 6) return 2;
    return 4;
  endfunction

  // One full instruction; wait_cyc is how many READ/WRITE cycles pass before ready.
  task automatic applyStimulus(input int op_idx, input logic [4:0] rd_i, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [11:0] imm, input int wait_cyc,
                               input logic [31:0] rdata, input logic [47:0] extra);
    logic [47:0] flags;
    logic [31:0] ea;
    logic [31:0] exp_data;
    logic [31:0] exp_ld;
    logic [31:0] lane;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_bsize;
    int eff;
    int size;
    int off;
    bit ld;
    bit sgn;
    bit mis;
    bit fault;

    flags = extra | (48'd1 << (29 + op_idx));
    eff = 0;
    for (int b = 7; b >= 0; b--)
      if (flags[29 + b]) eff = b;
    ld    = (eff < 5);
    sgn   = (eff == 0 || eff == 2 || eff == 4);
    size  = op_size(eff);
    ea    = rs1 + {{20{imm[11]}}, imm};
    off   = int'(ea % 32'd4);
    mis   = (ea % 32'(size)) != 32'd0;
    fault = (wait_cyc >= TO);
    exp_data  = rs2 << (8 * off);
    exp_strb  = 4'(((1 << size) - 1) << off);
    exp_bsize = (size == 4) ? 2'd0 : (size == 1) ? 2'd1 : 2'd2;
    lane = rdata >> (8 * off);
    if (size == 1) begin
      exp_ld = {24'd0, lane[7:0]};
      if (sgn && lane[7]) exp_ld = exp_ld | 32'hFFFF_FF00;
    end else if (size == 2) begin
      exp_ld = {16'd0, lane[15:0]};
      if (sgn && lane[15]) exp_ld = exp_ld | 32'hFFFF_0000;
    end else begin
      exp_ld = lane;
    end

    inst_flags = flags;
    rd         = rd_i;
    rs1_data   = rs1;
    rs2_data   = rs2;
    imm_2031   = imm;
    #1;
    checkOutput("busy_issue", 64'(busy_flag), 64'd1);
    checkOutput("wb_wait_issue", 64'(wb_rd_wait), 64'(ld));
    tick();
    inst_flags = '0;
    rs1_data   = $urandom;
    rs2_data   = $urandom;
    imm_2031   = 12'($urandom);
    rd         = 5'($urandom);

    if (mis) begin
      checkOutput("mis_exc_valid", 64'(exc_valid), 64'd1);
      checkOutput("mis_exc_cause", 64'(exc_cause), ld ? 64'd4 : 64'd6);
      checkOutput("mis_exc_addr", 64'(exc_addr), 64'(ea));
      checkOutput("mis_no_bus", 64'({mem_read_en, mem_write_en}), 64'd0);
      checkOutput("mis_busy", 64'(busy_flag), 64'd1);
      tick();
      checkOutput("mis_exc_clear", 64'({exc_valid, rd_en}), 64'd0);
      return;
    end

    checkOutput("addr", 64'(mem_addr), 64'(ea));
    checkOutput("byte_size", 64'(byte_size), 64'(exp_bsize));
    checkOutput("en_pair", 64'({mem_read_en, mem_write_en}), ld ? 64'd2 : 64'd1);
    if (!ld) begin
      checkOutput("wr_data", 64'(mem_data), 64'(exp_data));
      checkOutput("wr_strb", 64'(mem_wstrb), 64'(exp_strb));
    end

    for (int i = 0; i < TO; i++) begin
      checkOutput(ld ? "rd_en_hold" : "wr_en_hold", 64'(ld ? mem_read_en : mem_write_en), 64'd1);
      if (i == wait_cyc) begin
        if (ld) begin
          mem_read_ready = 1'b1;
          mem_data_in    = rdata;
        end else begin
          mem_write_ready = 1'b1;
        end
      end else begin
        mem_data_in = $urandom;
      end
      tick();
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      if (i == wait_cyc) break;
    end

    if (fault) begin
      checkOutput("to_exc_valid", 64'(exc_valid), 64'd1);
      checkOutput("to_exc_cause", 64'(exc_cause), ld ? 64'd5 : 64'd7);
      checkOutput("to_exc_addr", 64'(exc_addr), 64'(ea));
      checkOutput("to_en_drop", 64'({mem_read_en, mem_write_en, rd_en}), 64'd0);
      tick();
      checkOutput("to_exc_clear", 64'(exc_valid), 64'd0);
    end else begin
      checkOutput("done_rd_en", 64'(rd_en), 64'(ld));
      checkOutput("done_busy", 64'({busy_flag, wb_rd_wait}), 64'd0);
      checkOutput("done_en_drop", 64'({mem_read_en, mem_write_en, mem_wstrb}), 64'd0);
      checkOutput("done_rd_out", 64'(rd_out), ld ? 64'(rd_i) : 64'd0);
      if (ld) checkOutput("rd_data", 64'(rd_data), 64'(exp_ld));
      tick();
      checkOutput("rd_en_pulse", 64'({rd_en, exc_valid}), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rs1;
    logic [31:0] ea;
    logic [11:0] imm;
    logic [47:0] extra;
    int op;
    int w;

    rst             = 1'b1;
    rd              = '0;
    rs1_data        = '0;
    rs2_data        = '0;
    imm_2031        = '0;
    inst_flags      = '0;
    mem_data_in     = '0;
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    #12;
    checkOutput("reset_ctrl", 64'({mem_read_en, mem_write_en, rd_en, exc_valid, busy_flag, wb_rd_wait}), 64'd0);
    checkOutput("reset_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset_rd_data", 64'(rd_data), 64'd0);
    rst = 1'b0;
    tick();

    applyStimulus(0, 5'd1, 32'h1000, 32'd0, 12'hFFF, 0, 32'h8000_0000, '0);
    applyStimulus(1, 5'd2, 32'h1000, 32'd0, 12'hFFF, 0, 32'h8000_0000, '0);
    applyStimulus(3, 5'd3, 32'h1000, 32'd0, 12'h002, 0, 32'hBEEF_1234, '0);
    applyStimulus(5, 5'd4, 32'h2000, 32'h0000_00A5, 12'h003, 3, 32'd0, '0);
    applyStimulus(4, 5'd5, 32'h2000, 32'd0, 12'h002, 0, 32'd0, '0);
    applyStimulus(6, 5'd6, 32'h2000, 32'h1234, 12'h001, 0, 32'd0, '0);
    applyStimulus(4, 5'd7, 32'h4000, 32'd0, 12'h010, 20, 32'd0, '0);
    applyStimulus(4, 5'd8, 32'h4000, 32'd0, 12'h010, 1, 32'hCAFE_F00D, '0);
    applyStimulus(2, 5'd9, 32'h5000, 32'd0, 12'h802, TO - 1, 32'h8001_7FFF, '0);
    applyStimulus(7, 5'd10, 32'h6000, 32'h1357_9BDF, 12'h004, TO, 32'd0, '0);
    applyStimulus(0, 5'd11, 32'h7000, 32'd0, 12'h001, 0, 32'h0000_7F00, 48'h00_1000_0000_0000 | (48'd1 << 36));

    // Reset in the middle of a write must drop the request without a writeback.
    inst_flags = 48'd1 << 34;
    rs1_data   = 32'h3000;
    rs2_data   = 32'h5A;
    imm_2031   = 12'h000;
    #1;
    tick();
    checkOutput("rst_wr_en_before", 64'(mem_write_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_drop", 64'(mem_write_en), 64'd0);
    inst_flags = '0;
    #2 rst = 1'b0;
    tick();
    checkOutput("rst_after_ctrl", 64'({mem_read_en, mem_write_en, rd_en, exc_valid, busy_flag}), 64'd0);
    checkOutput("rst_after_data", 64'({mem_addr, mem_data}), 64'd0);
    checkOutput("rst_after_rd", 64'(rd_data), 64'd0);
    checkOutput("rst_after_exc", 64'({exc_cause, exc_addr}), 64'd0);

    for (int n = 0; n < 80; n++) begin
      op    = int'($urandom_range(0, 7));
      extra = {16'($urandom), 32'($urandom)} & ~MEM_MASK;
      if ($urandom_range(0, 3) == 0 && op < 7)
        extra = extra | (48'd1 << (29 + int'($urandom_range(op + 1, 7))));
      rs1 = $urandom;
      imm = 12'($urandom);
      ea  = rs1 + {{20{imm[11]}}, imm};
      if ($urandom_range(0, 3) != 0) rs1 = rs1 - (ea % 32'(op_size(op)));
      case ($urandom_range(0, 5))
        0, 1, 2: w = int'($urandom_range(0, 2));
        3:       w = TO - 1;
        4:       w = TO;
        default: w = int'($urandom_range(3, 5));
      endcase
      applyStimulus(op, 5'($urandom), rs1, $urandom, imm, w, $urandom, extra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_lsu.md
Name: ex_lsu

Overview:
Parametrised load/store execution unit, the successor to the current memory-access execute stage. It sits between decode (`inst_flags`, register operands) and the data-bus master. It adds:
- correct RISC-V sign/zero extension;
- byte-lane alignment with write strobes;
- misalignment detection;
- a bus timeout that raises an access-fault exception instead of hanging the pipeline.

Parameters:
- XLEN, 32, datapath/bus width; legal values 32 or 64.
- ADDR_W, 32, width of `mem_addr`; the effective address is truncated to ADDR_W.
- TIMEOUT_CYC, 256, cycles in READ/WRITE before access fault; 0 disables the timeout.
- MISALIGN_TRAP, 1, 1 = misaligned access raises exception; 0 = forced down to the natural alignment (low bits cleared).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd  in  5  destination register of the current instruction.
- rs1_data  in  XLEN  base address operand.
- rs2_data  in  XLEN  store data operand.
- imm_2031  in  12  instruction immediate, always sign-extended.
- inst_flags  in  48  one-hot decode flags: [29] lb, [30] lbu, [31] lh, [32] lhu, [33] lw, [34] sb, [35] sh, [36] sw.
- mem_data_in  in  XLEN  read data, full bus word.
- mem_read_ready  in  1  read completes this cycle.
- mem_write_ready  in  1  write accepted this cycle.
- mem_addr  out  ADDR_W  byte address.
- mem_data  out  XLEN  lane-aligned write data.
- mem_wstrb  out  XLEN/8  byte-lane write strobes.
- byte_size  out  2  0 = word, 1 = byte, 2 = half.
- mem_read_en  out  1  read request, level, held until ready.
- mem_write_en  out  1  write request, level, held until ready.
- busy_flag  out  1  pipeline stall request.
- wb_rd_wait  out  1  rd value pending (hazard interlock).
- rd_out  out  5  destination register for writeback.
- rd_en  out  1  one-cycle writeback strobe.
- rd_data  out  XLEN  extended load result.
- exc_valid  out  1  one-cycle exception strobe.
- exc_cause  out  4  4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault.
- exc_addr  out  ADDR_W  faulting effective address.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Asserting rst mid-access drops `mem_*_en` immediately and no writeback or exception occurs.
- States: IDLE, READ, WRITE, DONE, ERR.
- Effective address: `ea = rs1_data + sext(imm_2031)` for all eight ops, including lbu/lhu. Lane offset `off = ea[log2(XLEN/8)-1:0]`.
- IDLE with a memory flag set:
  - Capture op, rd, ea, and the shifted store data `rs2_data << 8*off`.
  - Misaligned (half with ea[0]=1, word with ea[1:0]≠0) and MISALIGN_TRAP=1 → ERR with the misaligned cause; no bus enable is asserted.
  - Otherwise a load → READ with `mem_read_en`=1 next cycle; a store → WRITE with `mem_write_en`=1 and `mem_wstrb` set next cycle.
  - Byte strobe = 1 lane; half = 2 lanes; word = 4 lanes at `off`.
  - Flags with more than one memory bit set: lowest index wins.
- READ:
  - On `mem_read_ready`, extract the lane at `off` and extend: lb/lh sign-extend to XLEN; lbu/lhu zero-extend; lw sign-extends (relevant at XLEN=64).
  - Register `rd_data`, set `rd_en`=1, drop `mem_read_en`, go to DONE.
- WRITE: on `mem_write_ready`, drop `mem_write_en` and `mem_wstrb`, go to DONE.
- Timeout:
  - The counter increments each cycle in READ/WRITE without ready.
  - When it reaches TIMEOUT_CYC, drop enables and go to ERR with cause 5 or 7.
  - A ready arriving in the same cycle as the timeout wins, and the access completes normally.
- ERR: `exc_valid`=1 for exactly one cycle, with `exc_addr`=ea; `rd_en` stays 0; then IDLE.
- DONE: `rd_en` cleared; go to IDLE. The next instruction is accepted in the following IDLE cycle.
- Latency: load with zero-wait memory = issue cycle + 1 READ cycle, then `rd_en` visible in the DONE cycle. A store takes the same number of cycles.
- `busy_flag` (combinational): 1 when (IDLE and a memory flag is set) or in READ, WRITE or ERR; 0 in DONE.
- `wb_rd_wait` (combinational): 1 in READ, or in IDLE with a load flag set.
- `rd_out`: the captured rd for loads, 0 for stores and non-memory ops.
- `inst_flags` and operand changes while not in IDLE are ignored.

Decomposition:
- Package `lsu_pkg` holds:
  - state encodings;
  - `inst_flags` bit indices 29..36;
  - exception cause constants 4..7;
  - byte_size encodings.
- Sub-module `lsu_align` (combinational), which produces:
  - store shift and strobe generation from (op, off, rs2_data);
  - load lane extraction and extension from (op, off, mem_data_in).

Test Plan:
- lb, rs1=0x1000, imm=-1 (0xFFF), memory returns 0x80_00_00_00 at 0x0FFC → mem_addr=0x0FFF; rd_data=0xFFFFFF80; rd_en pulses 1 cycle; busy_flag low in DONE.
- lbu with the same stimulus → rd_data=0x00000080; lhu at ea=0x1002 with data 0xBEEF_1234 → 0x0000BEEF.
- sb rs2=0xA5, ea=0x2003 → mem_write_en=1, mem_data=0xA5000000, mem_wstrb=4'b1000; held for 3 stall cycles until mem_write_ready; no rd_en.
- lw at ea=0x2002 with MISALIGN_TRAP=1 → no mem_read_en; exc_valid 1 cycle, exc_cause=4, exc_addr=0x2002; sh at 0x2001 → cause 6.
- lw with TIMEOUT_CYC=8 and ready never asserted → mem_read_en drops after 8 cycles; exc_cause=5; returns to IDLE; a subsequent lw completes normally.
- rst pulsed while in WRITE → mem_write_en falls asynchronously; after release, state IDLE, all outputs 0, no exc_valid.
